fft_stage_permuter: RTL

Registered, parametrised inter-stage index permuter for the pipelined radix-2 FFT datapath. It sits between butterfly stages, or before the output, and reorders N complex samples under a per-frame mode. The mode is either identity, a swap of index bit 0 with index bit s, or a full bit-reversal. Frames move one per cycle under a valid/ready handshake, so back-pressure from downstream stages propagates without data loss.

---
 rtl/fft_stage_permuter_pkg.sv | 37 +++
 rtl/fft_index_perm.sv | 29 ++
 rtl/fft_stage_permuter.sv | 85 ++++++++
 3 files changed

// File: rtl/fft_stage_permuter_pkg.sv
// rtl/fft_stage_permuter_pkg.sv - shared FFT index/mode helpers for the stage permuter
package fft_stage_permuter_pkg;

  localparam int MODE_IDENTITY = 0;

  // Bit-reversal mode number equals the index width of the frame.
  function automatic int mode_bitrev(input int log2n);
    return log2n;
  endfunction

  // Lowest bit of sample k on a packed bus of dw-bit samples.
  function automatic int sample_lsb(input int k, input int dw);
    return k * dw;
  endfunction

  // Source index p(j) for output sample j under a mode; illegal modes fall back to identity.
  function automatic int perm_index(input int j, input int mode, input int log2n);
    int r;
    int b0;
    int bs;
    r = j;
    if (mode == MODE_IDENTITY) begin
      r = j;
    end else if (mode >= 1 && mode < log2n) begin
      b0 = j & 1;
      bs = (j >> mode) & 1;
      r  = (j & ~((1 << mode) | 1)) | bs | (b0 << mode);
    end else if (mode == mode_bitrev(log2n)) begin
      r = 0;
      for (int b = 0; b < 32; b++) begin
        if (b < log2n) r = r | (((j >> b) & 1) << (log2n - 1 - b));
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_index_perm.sv
// rtl/fft_index_perm.sv - combinational mode-selected N-way permutation of one packed bus
module fft_index_perm
  import fft_stage_permuter_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int LOG2_N     = 5,
  parameter int SW         = 3
) (
  input  logic [SW-1:0]                          mode,
  input  logic [(1<<LOG2_N)*DATA_WIDTH-1:0]      din,
  output logic [(1<<LOG2_N)*DATA_WIDTH-1:0]      dout
);

  localparam int N = 1 << LOG2_N;

  // Pure wiring per legal mode; anything else (mode 0 or illegal) passes straight through.
  always_comb begin
    dout = din;
    for (int m = 1; m <= LOG2_N; m++) begin
      if (int'(mode) == m) begin
        for (int j = 0; j < N; j++) begin
          dout[sample_lsb(j, DATA_WIDTH) +: DATA_WIDTH] =
            din[sample_lsb(perm_index(j, m, LOG2_N), DATA_WIDTH) +: DATA_WIDTH];
        end
      end
    end
  end

endmodule

// File: rtl/fft_stage_permuter.sv
// rtl/fft_stage_permuter.sv - registered inter-stage FFT index permuter with valid/ready
module fft_stage_permuter
  import fft_stage_permuter_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int LOG2_N     = 5,
  parameter int CNT_WIDTH  = 16,
  localparam int SW        = $clog2(LOG2_N + 2),
  localparam int BW        = (1 << LOG2_N) * DATA_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [SW-1:0]        in_mode,
  input  logic [BW-1:0]        in_real,
  input  logic [BW-1:0]        in_imag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BW-1:0]        out_real,
  output logic [BW-1:0]        out_imag,
  output logic [SW-1:0]        out_mode,
  output logic [CNT_WIDTH-1:0] frame_cnt,
  output logic                 mode_err
);

  logic [BW-1:0] perm_real;
  logic [BW-1:0] perm_imag;
  logic          in_xfer;
  logic          out_xfer;
  logic          mode_illegal;

  fft_index_perm #(.DATA_WIDTH(DATA_WIDTH), .LOG2_N(LOG2_N), .SW(SW)) u_perm_real (
    .mode (in_mode),
    .din  (in_real),
    .dout (perm_real)
  );

  fft_index_perm #(.DATA_WIDTH(DATA_WIDTH), .LOG2_N(LOG2_N), .SW(SW)) u_perm_imag (
    .mode (in_mode),
    .din  (in_imag),
    .dout (perm_imag)
  );

  assign in_ready     = !out_valid || out_ready;
  assign in_xfer      = in_valid && in_ready;
  assign out_xfer     = out_valid && out_ready;
  assign mode_illegal = int'(in_mode) > mode_bitrev(LOG2_N);

  // Single output bank: load on accept, drain when delivered with nothing new behind it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_real  <= '0;
      out_imag  <= '0;
      out_mode  <= '0;
    end else if (in_xfer) begin
      out_valid <= 1'b1;
      out_real  <= perm_real;
      out_imag  <= perm_imag;
      out_mode  <= in_mode;
    end else if (out_xfer) begin
      out_valid <= 1'b0;
    end
  end

  // Delivered-frame counter, wraps naturally at its width.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= '0;
    end else if (out_xfer) begin
      frame_cnt <= frame_cnt + CNT_WIDTH'(1);
    end
  end

  // Sticky flag for any accepted frame carrying an out-of-range mode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_err <= 1'b0;
    end else if (in_xfer && mode_illegal) begin
      mode_err <= 1'b1;
    end
  end

endmodule
